adiabatic_pclk_gen: RTL and testbench

Digital generator for the four-phase trapezoidal power clocks (clkpos/clkneg pairs) that drive cascaded adiabatic logic stages. It emits a per-stage level code for an external DAC/driver, staggers stages by one phase each, and samples each stage's logic output during its hold phase. It is the supply/observation end of the power-clock interface consumed by the MIPS25 adiabatic gates.

---
 rtl/adiabatic_pclk_gen.sv | 151 +++++++++++++++
 tb/tb_adiabatic_pclk_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/adiabatic_pclk_gen.sv
// rtl/adiabatic_pclk_gen.sv - four-phase trapezoidal power-clock level generator with staggered stages
// Optional hold-phase sampler enabled by defining ADPCLK_SAMPLE_EN.
module adiabatic_pclk_gen #(
  parameter int PHASE_CYCLES = 4,
  parameter int LEVEL_W      = 4,
  parameter int STAGES       = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic [STAGES-1:0]         data,
  output logic [STAGES*LEVEL_W-1:0] clkpos,
  output logic [STAGES*LEVEL_W-1:0] clkneg,
  output logic                      busy,
  output logic [STAGES-1:0]         sample,
  output logic [STAGES-1:0]         sample_valid
);
  localparam int IW = $clog2(PHASE_CYCLES);
  localparam int PW = LEVEL_W + 8;
  localparam logic [LEVEL_W-1:0] LMAX = {LEVEL_W{1'b1}};

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {PH_RISE, PH_HOLD, PH_FALL, PH_REST} phase_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [1:0]                gph_q, gph_d;
  logic                      drain_q, drain_d;
  logic [STAGES-1:0]         active_q, active_d;
  logic [STAGES-1:0]         hold_end;
  logic [STAGES*LEVEL_W-1:0] clkpos_q, clkpos_d;
  logic [STAGES*LEVEL_W-1:0] clkneg_q, clkneg_d;
  logic                      busy_q, busy_d;
  logic                      last_cyc;
  logic [LEVEL_W-1:0]        ramp;
  logic [LEVEL_W-1:0]        lvl;
  phase_t                    ph;

  assign last_cyc = (idx_q == IW'(PHASE_CYCLES - 1));
  // Truncating ramp step; the product cannot overflow PW bits for P <= 256.
  assign ramp = LEVEL_W'(((PW'(idx_q) + PW'(1)) * PW'(LMAX)) / PW'(PHASE_CYCLES));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gph_d    = gph_q;
    drain_d  = drain_q;
    active_d = active_q;
    hold_end = '0;
    clkpos_d = '0;
    clkneg_d = {STAGES{LMAX}};
    busy_d   = 1'b0;
    ph       = PH_REST;
    lvl      = '0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_RUN;
          idx_d   = '0;
          gph_d   = '0;
        end
      end
      S_RUN: begin
        drain_d = drain_q | ~run;
        for (int k = 0; k < STAGES; k++) begin
          ph = phase_t'(gph_q - 2'(k));
          // A stage may only join at the very start of its RISE, never mid-trapezoid.
          if (ph == PH_RISE && idx_q == '0 && run && !drain_q) active_d[k] = 1'b1;
          if (ph == PH_REST && idx_q == '0) active_d[k] = 1'b0;
          lvl = '0;
          if (active_d[k]) begin
            case (ph)
              PH_RISE: lvl = ramp;
              PH_HOLD: lvl = LMAX;
              PH_FALL: lvl = LMAX - ramp;
              default: lvl = '0;
            endcase
          end
          clkpos_d[k*LEVEL_W +: LEVEL_W] = lvl;
          clkneg_d[k*LEVEL_W +: LEVEL_W] = LMAX - lvl;
          hold_end[k] = active_d[k] && (ph == PH_HOLD) && last_cyc;
        end
        if (last_cyc) begin
          idx_d = '0;
          gph_d = gph_q + 2'd1;
        end else begin
          idx_d = idx_q + IW'(1);
        end
        if (drain_d && active_d == '0) begin
          state_d = S_IDLE;
          drain_d = 1'b0;
          idx_d   = '0;
          gph_d   = '0;
        end
        busy_d = (|active_d) | drain_d;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      gph_q    <= '0;
      drain_q  <= 1'b0;
      active_q <= '0;
      clkpos_q <= '0;
      clkneg_q <= {STAGES{LMAX}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gph_q    <= gph_d;
      drain_q  <= drain_d;
      active_q <= active_d;
      clkpos_q <= clkpos_d;
      clkneg_q <= clkneg_d;
      busy_q   <= busy_d;
    end
  end

  assign clkpos = clkpos_q;
  assign clkneg = clkneg_q;
  assign busy   = busy_q;

`ifdef ADPCLK_SAMPLE_EN
  logic [STAGES-1:0] sample_q, cap_q, sample_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q       <= '0;
      cap_q          <= '0;
      sample_valid_q <= '0;
    end else begin
      sample_q       <= (sample_q & ~hold_end) | (data & hold_end);
      cap_q          <= hold_end;
      sample_valid_q <= cap_q;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
`else
  logic unused_sampler;
  assign unused_sampler = ^{data, hold_end};
  assign sample         = '0;
  assign sample_valid   = '0;
`endif

endmodule

// File: tb/tb_adiabatic_pclk_gen.sv
// tb/tb_adiabatic_pclk_gen.sv - scoreboard bench for adiabatic_pclk_gen (P=4 two-stage and P=3 one-stage)
module tb_adiabatic_pclk_gen;
  logic       clk = 1'b0;
  logic       rst, run, run3, data3;
  logic [1:0] data;
  logic [7:0] clkpos, clkneg;
  logic       busy;
  logic [1:0] sample, sample_valid;
  logic [3:0] clkpos3, clkneg3;
  logic       busy3, sample3, sample_valid3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0, t3;

  typedef struct {
    int         cyc;
    logic [3:0] p0;
    logic [3:0] p1;
    logic [3:0] p3;
    logic       b;
    logic       b3;
  } exp_t;

  typedef struct {
    int   cyc;
    int   k;
    logic v;
  } smp_t;

  exp_t eq[$];
  smp_t sq[$];
  exp_t e;
  smp_t s;

  logic [3:0] seq4 [16] = '{4'd3, 4'd7, 4'd11, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15,
                            4'd12, 4'd8, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] seq3 [12] = '{4'd5, 4'd10, 4'd15, 4'd15, 4'd15, 4'd15,
                            4'd10, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};

  adiabatic_pclk_gen #(.PHASE_CYCLES(4), .LEVEL_W(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .run(run), .data(data),
    .clkpos(clkpos), .clkneg(clkneg), .busy(busy),
    .sample(sample), .sample_valid(sample_valid)
  );

  adiabatic_pclk_gen #(.PHASE_CYCLES(3), .LEVEL_W(4), .STAGES(1)) dut3 (
    .clk(clk), .rst(rst), .run(run3), .data(data3),
    .clkpos(clkpos3), .clkneg(clkneg3), .busy(busy3),
    .sample(sample3), .sample_valid(sample_valid3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  task automatic sample_pop(input int k, input logic v);
    if (sq.size() == 0) begin
      chk("unexpected_sample_valid", k, -1);
    end else begin
      s = sq.pop_front();
      chk("sample_cycle", cyc, s.cyc);
      chk("sample_stage", k, s.k);
      chk("sample_value", int'(v), int'(s.v));
    end
  endtask

  task automatic drive(input logic r_rst, input logic r_run, input logic [1:0] r_data,
                       input logic r_run3, input int p0, input int p1, input int b,
                       input int p3, input int b3);
    rst   = r_rst;
    run   = r_run;
    data  = r_data;
    run3  = r_run3;
    data3 = 1'b1;
    eq.push_back('{cyc + 1, 4'(p0), 4'(p1), 4'(p3), b != 0, b3 != 0});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].cyc == cyc) begin
      e = eq.pop_front();
      chk("clkpos", int'(clkpos), int'({e.p1, e.p0}));
      chk("clkneg", int'(clkneg), int'({4'hF - e.p1, 4'hF - e.p0}));
      chk("busy", int'(busy), int'(e.b));
      chk("clkpos3", int'(clkpos3), int'(e.p3));
      chk("clkneg3", int'(clkneg3), int'(4'hF - e.p3));
      chk("busy3", int'(busy3), int'(e.b3));
    end
`ifdef ADPCLK_SAMPLE_EN
    for (int k = 0; k < 2; k++) if (sample_valid[k]) sample_pop(k, sample[k]);
    if (sample_valid3) sample_pop(8, sample3);
`else
    if (cyc > 0) chk("sampler_tied_off", int'({sample_valid, sample, sample_valid3, sample3}), 0);
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; run3 = 1'b0; data = 2'b00; data3 = 1'b1;
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Continuous run, then drain started in stage-0 HOLD with a mid-drain run pulse.
    t0 = cyc + 1;
`ifdef ADPCLK_SAMPLE_EN
    sq.push_back('{t0 + 9,  0, 1'b1});
    sq.push_back('{t0 + 13, 1, 1'b0});
    sq.push_back('{t0 + 25, 0, 1'b1});
    sq.push_back('{t0 + 29, 1, 1'b0});
    sq.push_back('{t0 + 41, 0, 1'b0});
    sq.push_back('{t0 + 45, 1, 1'b1});
`endif
    drive(0, 1, 2'b01, 0, 0, 0, 0, 0, 0);
    for (int j = 0; j <= 50; j++) begin
      drive(0, (j < 37) || (j >= 42 && j <= 45), (j < 32) ? 2'b01 : 2'b10, 0,
            (j < 48) ? int'(seq4[j % 16]) : 0,
            (j < 4) ? 0 : int'(seq4[(j - 4) % 16]),
            (j < 48) ? 1 : 0, 0, 0);
    end

    // Abrupt reset during stage-0 RISE, then restart from the first ramp code.
    drive(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2'b00, 0, 3, 0, 1, 0, 0);
    drive(0, 1, 2'b00, 0, 7, 0, 1, 0, 0);
    drive(1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2'b00, 0, 3, 0, 1, 0, 0);
    drive(0, 1, 2'b00, 0, 7, 0, 1, 0, 0);

    // P=3 truncation, single period with run dropped during RISE.
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    t3 = cyc + 1;
`ifdef ADPCLK_SAMPLE_EN
    sq.push_back('{t3 + 7, 8, 1'b1});
`endif
    drive(0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 12; j++) begin
      drive(0, 0, 2'b00, j < 2, 0, 0, 0, int'(seq3[j]), (j < 9) ? 1 : 0);
    end

    repeat (3) @(negedge clk);
`ifdef ADPCLK_SAMPLE_EN
    chk("sample_pulses_missing", sq.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
